// File: rtl/hms_set_ctrl_pkg.sv
// Shared types and constants for the hh/mm/ss time-keeping and set-mode controller.
package hms_set_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_SET_HH = 2'd1,
    ST_SET_MM = 2'd2,
    ST_SET_SS = 2'd3
  } state_e;

  localparam logic [1:0] FS_NONE = 2'd0;
  localparam logic [1:0] FS_HH   = 2'd1;
  localparam logic [1:0] FS_MM   = 2'd2;
  localparam logic [1:0] FS_SS   = 2'd3;

  localparam int unsigned HH_MAX = 23;
  localparam int unsigned MS_MAX = 59;

  // Packs {pm, hh12} for a 24-hour value; midnight and noon both show as 12.
  function automatic logic [4:0] to_12h(input logic [4:0] h24);
    logic [3:0] h12;
    logic       pm;
    if (h24 == 5'd0) begin
      h12 = 4'd12;
      pm  = 1'b0;
    end else if (h24 < 5'd12) begin
      h12 = h24[3:0];
      pm  = 1'b0;
    end else if (h24 == 5'd12) begin
      h12 = 4'd12;
      pm  = 1'b1;
    end else begin
      h12 = 4'(h24 - 5'd12);
      pm  = 1'b1;
    end
    return {pm, h12};
  endfunction

endpackage

// File: rtl/hms_wrap_cnt.sv
// Modulo-(MAX+1) counter. 'inc' is a local edit step that never carries out;
// 'carry_in' is a chained step that raises carry_out when it wraps.
module hms_wrap_cnt #(
  parameter int unsigned W   = 6,
  parameter int unsigned MAX = 59
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         carry_in,
  output logic [W-1:0] value,
  output logic         carry_out
);

  logic [W-1:0] value_q, value_d;
  logic         wrap;

  assign wrap      = (value_q == W'(MAX));
  assign carry_out = carry_in && wrap;
  assign value     = value_q;

  // Next count: step on either request, wrapping to zero at MAX.
  always_comb begin
    value_d = value_q;
    if (inc || carry_in) begin
      if (wrap) begin
        value_d = {W{1'b0}};
      end else begin
        value_d = value_q + W'(1'b1);
      end
    end else begin
      value_d = value_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= {W{1'b0}};
    end else begin
      value_q <= value_d;
    end
  end

endmodule

// File: rtl/hms_set_ctrl.sv
// HEX clock time-keeping / time-setting controller.
// Optional 12-hour outputs (hh12, pm) are built when HMS_SET_CTRL_12H_EN is defined.
module hms_set_ctrl
  import hms_set_ctrl_pkg::*;
#(
  parameter int unsigned BLINK_CYCLES  = 12500000,
  parameter int unsigned TIMEOUT_TICKS = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       key_mode,
  input  logic       key_next,
  input  logic       key_inc,
  output logic [4:0] hh,
  output logic [5:0] mm,
  output logic [5:0] ss,
  output logic       setting,
  output logic [1:0] field_sel,
  output logic       blank,
  output logic       day_carry
`ifdef HMS_SET_CTRL_12H_EN
  ,
  output logic [3:0] hh12,
  output logic       pm
`endif
);

  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);

  state_e        state_q, state_d;
  logic [BW-1:0] blink_q, blink_d;
  logic [TW-1:0] to_q, to_d;
  logic          blank_q, blank_d;
  logic          setting_q, setting_d;
  logic          day_carry_q;

  logic any_key, run_tick, edit;
  logic ss_carry, mm_carry, hh_carry;

  assign any_key  = key_mode || key_next || key_inc;
  // key_mode wins over a same-cycle tick and over the other keys.
  assign run_tick = (state_q == ST_RUN) && tick_1hz && !key_mode;
  assign edit     = key_inc && !key_mode;

  hms_wrap_cnt #(.W(6), .MAX(MS_MAX)) u_ss (
    .clk(clk), .rst_n(rst_n), .inc(edit && (state_q == ST_SET_SS)),
    .carry_in(run_tick), .value(ss), .carry_out(ss_carry)
  );

  hms_wrap_cnt #(.W(6), .MAX(MS_MAX)) u_mm (
    .clk(clk), .rst_n(rst_n), .inc(edit && (state_q == ST_SET_MM)),
    .carry_in(ss_carry), .value(mm), .carry_out(mm_carry)
  );

  hms_wrap_cnt #(.W(5), .MAX(HH_MAX)) u_hh (
    .clk(clk), .rst_n(rst_n), .inc(edit && (state_q == ST_SET_HH)),
    .carry_in(mm_carry), .value(hh), .carry_out(hh_carry)
  );

  // Mode FSM and key-inactivity timeout.
  always_comb begin
    state_d = state_q;
    to_d    = to_q;
    case (state_q)
      ST_RUN: begin
        to_d = {TW{1'b0}};
        if (key_mode) begin
          state_d = ST_SET_HH;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        if (key_mode) begin
          state_d = ST_RUN;
        end else if (key_next) begin
          case (state_q)
            ST_SET_HH: state_d = ST_SET_MM;
            ST_SET_MM: state_d = ST_SET_SS;
            default:   state_d = ST_RUN;
          endcase
        end else if (tick_1hz && (to_q == TW'(TIMEOUT_TICKS - 1))) begin
          state_d = ST_RUN;
        end else begin
          state_d = state_q;
        end
        if (any_key || (state_d == ST_RUN)) begin
          to_d = {TW{1'b0}};
        end else if (tick_1hz) begin
          to_d = to_q + TW'(1'b1);
        end else begin
          to_d = to_q;
        end
      end
    endcase
    setting_d = (state_d != ST_RUN);
  end

  // Blink phase: restarts solid on any key or mode change so edits show at once.
  always_comb begin
    blink_d = blink_q;
    blank_d = blank_q;
    if ((state_q == ST_RUN) || any_key || (state_d != state_q)) begin
      blink_d = {BW{1'b0}};
      blank_d = 1'b0;
    end else if (blink_q == BW'(BLINK_CYCLES - 1)) begin
      blink_d = {BW{1'b0}};
      blank_d = ~blank_q;
    end else begin
      blink_d = blink_q + BW'(1'b1);
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      to_q        <= {TW{1'b0}};
      blink_q     <= {BW{1'b0}};
      blank_q     <= 1'b0;
      setting_q   <= 1'b0;
      day_carry_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      to_q        <= to_d;
      blink_q     <= blink_d;
      blank_q     <= blank_d;
      setting_q   <= setting_d;
      day_carry_q <= hh_carry;
    end
  end

  assign setting   = setting_q;
  assign field_sel = state_q;
  assign blank     = blank_q;
  assign day_carry = day_carry_q;

`ifdef HMS_SET_CTRL_12H_EN
  logic [3:0] hh12_q, hh12_d;
  logic       pm_q, pm_d;
  logic [4:0] hh_nx;
  logic       hh_step;

  assign hh_step = mm_carry || (edit && (state_q == ST_SET_HH));
  assign hh_nx   = (hh == 5'(HH_MAX)) ? 5'd0 : (hh + 5'd1);

  // 12-hour view tracks every hh step so it shares hh's latency.
  always_comb begin
    if (hh_step) begin
      {pm_d, hh12_d} = to_12h(hh_nx);
    end else begin
      {pm_d, hh12_d} = {pm_q, hh12_q};
    end
  end

  // 12-hour view registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hh12_q <= 4'd12;
      pm_q   <= 1'b0;
    end else begin
      hh12_q <= hh12_d;
      pm_q   <= pm_d;
    end
  end

  assign hh12 = hh12_q;
  assign pm   = pm_q;
`endif

endmodule

// File: tb/tb_hms_set_ctrl.sv
// Directed self-checking bench for hms_set_ctrl (BLINK_CYCLES=4, TIMEOUT_TICKS=3).
module tb_hms_set_ctrl;

  logic       clk;
  logic       rst_n;
  logic       tick_1hz, key_mode, key_next, key_inc;
  logic [4:0] hh;
  logic [5:0] mm, ss;
  logic       setting, blank, day_carry;
  logic [1:0] field_sel;
`ifdef HMS_SET_CTRL_12H_EN
  logic [3:0] hh12;
  logic       pm;
`endif

  int checks = 0;
  int errors = 0;

  hms_set_ctrl #(.BLINK_CYCLES(4), .TIMEOUT_TICKS(3)) dut (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .key_mode(key_mode),
    .key_next(key_next), .key_inc(key_inc), .hh(hh), .mm(mm), .ss(ss),
    .setting(setting), .field_sel(field_sel), .blank(blank), .day_carry(day_carry)
`ifdef HMS_SET_CTRL_12H_EN
    , .hh12(hh12), .pm(pm)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock with the given one-cycle pulses; returns 1 time unit after the edge.
  task automatic step(input logic t, input logic m, input logic n, input logic i);
    tick_1hz = t; key_mode = m; key_next = n; key_inc = i;
    @(posedge clk);
    #1;
    tick_1hz = 1'b0; key_mode = 1'b0; key_next = 1'b0; key_inc = 1'b0;
  endtask

  task automatic incs(input int cnt);
    for (int k = 0; k < cnt; k++) step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic idles(input int cnt);
    for (int k = 0; k < cnt; k++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_hh"}, 32'(hh), 32'd0);
    chk({tag, "_mm"}, 32'(mm), 32'd0);
    chk({tag, "_ss"}, 32'(ss), 32'd0);
    chk({tag, "_setting"}, 32'(setting), 32'd0);
    chk({tag, "_field"}, 32'(field_sel), 32'd0);
    chk({tag, "_blank"}, 32'(blank), 32'd0);
    chk({tag, "_daycarry"}, 32'(day_carry), 32'd0);
`ifdef HMS_SET_CTRL_12H_EN
    chk({tag, "_hh12"}, 32'(hh12), 32'd12);
    chk({tag, "_pm"}, 32'(pm), 32'd0);
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    tick_1hz = 1'b0; key_mode = 1'b0; key_next = 1'b0; key_inc = 1'b0;
    #12;
    chk_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Load 23:59:58 through set mode.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("enter_setting", 32'(setting), 32'd1);
    chk("enter_field", 32'(field_sel), 32'd1);
    incs(23);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("next_field_mm", 32'(field_sel), 32'd2);
    incs(59);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    incs(58);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("exit_setting", 32'(setting), 32'd0);
    chk("load_hh", 32'(hh), 32'd23);
    chk("load_mm", 32'(mm), 32'd59);
    chk("load_ss", 32'(ss), 32'd58);

    // Midnight rollover.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("tick_ss59", 32'(ss), 32'd59);
    chk("tick_no_carry", 32'(day_carry), 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("roll_time", 32'({hh, mm, ss}), 32'd0);
    chk("roll_daycarry", 32'(day_carry), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("daycarry_1clk", 32'(day_carry), 32'd0);

    // Set hh 0 -> 3, tick in the middle must not move ss.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("set_tick_frozen_ss", 32'(ss), 32'd0);
    chk("set_tick_stay", 32'(setting), 32'd1);
    incs(2);
    chk("set_hh3", 32'(hh), 32'd3);

    // hh wraps 23 -> 0 without carry.
    incs(20);
    chk("set_hh23", 32'(hh), 32'd23);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("hh_wrap", 32'(hh), 32'd0);
    chk("hh_wrap_mm", 32'(mm), 32'd0);
    chk("hh_wrap_nocarry", 32'(day_carry), 32'd0);

    // Blink in SET_MM: toggles every 4 clocks, key clears it.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("blink_entry", 32'(blank), 32'd0);
    idles(3);
    chk("blink_3", 32'(blank), 32'd0);
    idles(1);
    chk("blink_4", 32'(blank), 32'd1);
    idles(3);
    chk("blink_7", 32'(blank), 32'd1);
    idles(1);
    chk("blink_8", 32'(blank), 32'd0);
    idles(4);
    chk("blink_12", 32'(blank), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("blink_key_clr", 32'(blank), 32'd0);
    chk("mm_inc1", 32'(mm), 32'd1);

    // inc + next at mm = 59.
    incs(58);
    chk("mm59", 32'(mm), 32'd59);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("incnext_mm", 32'(mm), 32'd0);
    chk("incnext_field", 32'(field_sel), 32'd3);
    chk("incnext_hh", 32'(hh), 32'd0);

    // Timeout after 3 idle ticks.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("to_2_setting", 32'(setting), 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("to_setting", 32'(setting), 32'd0);
    chk("to_field", 32'(field_sel), 32'd0);
    chk("to_ss", 32'(ss), 32'd0);
    chk("to_blank", 32'(blank), 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("after_to_tick", 32'(ss), 32'd1);

    // Simultaneous events.
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("run_tick_inc_ss", 32'(ss), 32'd2);
    chk("run_tick_inc_run", 32'(setting), 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("mode_beats_tick_ss", 32'(ss), 32'd2);
    chk("mode_beats_tick_fs", 32'(field_sel), 32'd1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    chk("abort_setting", 32'(setting), 32'd0);
    chk("abort_hh", 32'(hh), 32'd0);

    // Walk the fields with key_next back to RUN.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("walk_ss", 32'(field_sel), 32'd3);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("walk_run", 32'(setting), 32'd0);

`ifdef HMS_SET_CTRL_12H_EN
    chk("h12_0", 32'({pm, hh12}), 32'({1'b0, 4'd12}));
    step(1'b0, 1'b1, 1'b0, 1'b0);
    incs(12);
    chk("h12_12", 32'({pm, hh12}), 32'({1'b1, 4'd12}));
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("h12_13", 32'({pm, hh12}), 32'({1'b1, 4'd1}));
    step(1'b0, 1'b1, 1'b0, 1'b0);
`endif

    // Asynchronous reset in the middle of set mode.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("preset_setting", 32'(setting), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hms_set_ctrl.md
Name: hms_set_ctrl

Overview:
- Time-keeping and time-setting controller for the HEX clock display.
- Owns the hh/mm/ss registers, advances them on a 1 Hz strobe, and sequences a user set mode driven by debounced key pulses.
- Drives a field-select/blink mask to the LED7 formatter and a day-carry pulse to the date logic.
- Sits between the counter dividers / key debouncers and the binary-to-LED7 converters.

Parameters:
- BLINK_CYCLES, 12500000: clk cycles per blink half-period (4 Hz toggle at 50 MHz).
- TIMEOUT_TICKS, 10: tick_1hz strobes with no key activity before set mode auto-exits to RUN.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- tick_1hz  in  1  one-clk strobe, once per second, synchronous to clk.
- key_mode  in  1  one-clk pulse, debounced; enter/abort set mode.
- key_next  in  1  one-clk pulse; advance to next field.
- key_inc  in  1  one-clk pulse; increment selected field.
- hh  out  5  hours, 0..23.
- mm  out  6  minutes, 0..59.
- ss  out  6  seconds, 0..59.
- setting  out  1  high in any SET state.
- field_sel  out  2  0 = none, 1 = hh, 2 = mm, 3 = ss.
- blank  out  1  high when the selected field is to be blanked (blink off-phase).
- day_carry  out  1  one-clk pulse on the 23:59:59 to 00:00:00 rollover.

Behaviour:
- Single clock, one clk domain; asynchronous active-low reset.
- All outputs registered; a response to any input appears on the clk edge after it is sampled (1-cycle latency).
- Reset values: hh = mm = ss = 0, state RUN, setting = 0, field_sel = 0, blank = 0, day_carry = 0, blink counter = 0, timeout counter = 0.
- States: RUN, SET_HH, SET_MM, SET_SS. field_sel = 0/1/2/3 respectively; setting = (state != RUN).
- RUN + tick_1hz:
  - ss increments.
  - At ss = 59, ss goes to 0 and mm increments.
  - At mm = 59 with carry, mm goes to 0 and hh increments.
  - At hh = 23 with carry, hh goes to 0 and day_carry pulses for exactly 1 clk.
  - Values never exceed their maxima.
- RUN + key_mode: go to SET_HH; the time is frozen.
- SET states:
  - tick_1hz never advances the time. It increments the timeout counter.
  - key_inc increments only the selected field, wrapping 23 to 0 (hh) or 59 to 0 (mm, ss), with no carry. day_carry stays 0.
  - key_next: SET_HH to SET_MM, SET_MM to SET_SS, SET_SS to RUN.
  - key_mode: abort to RUN immediately; edits made so far are kept.
- Simultaneous events:
  - key_mode beats key_next and key_inc. In RUN it enters SET_HH, and any same-cycle tick is discarded.
  - key_inc + key_next in the same cycle: increment the current field, then advance.
  - RUN + tick + key_inc/key_next: the tick is applied and the keys are ignored.
- Timeout:
  - Any key pulse clears the timeout counter.
  - When the counter reaches TIMEOUT_TICKS in a SET state, go to RUN and clear the counter.
  - The counter is held at 0 in RUN.
- Blink:
  - The counter counts clk cycles in SET states only.
  - At BLINK_CYCLES-1 the counter wraps and blank toggles.
  - Any key pulse and any state change clear both the counter and blank, so an edited field is shown solid immediately.
  - blank = 0 whenever in RUN.
- Reset mid-set: return to RUN with the time at 00:00:00.

Optional Feature:
- Macro: HMS_SET_CTRL_12H_EN.
- When defined:
  - Adds output hh12 (4 bits, 1..12) and output pm (1 bit).
  - hh = 0 maps to hh12 = 12, pm = 0; hh = 12 maps to hh12 = 12, pm = 1; hh = 13..23 maps to hh12 = hh-12, pm = 1.
  - Both outputs are registered with the same latency as hh.
- When undefined: these ports do not exist. Internal hh is always 24-hour in both cases.

Decomposition:
- Shared package: state encoding (RUN = 2'd0, SET_HH = 2'd1, SET_MM = 2'd2, SET_SS = 2'd3), field_sel codes, and max constants HH_MAX = 23, MS_MAX = 59.
- One natural sub-module, hms_wrap_cnt: a parameterised modulo counter with inc, carry_in, wrap and carry_out. Instantiate it 3 times.
- The FSM, blink counter and timeout counter stay in the top.

Test Plan:
- Reset to 23:59:58, then 2 ticks: 23:59:59, then 00:00:00 with day_carry high for exactly 1 clk.
- key_mode, then 3 key_inc: state SET_HH, hh 0 to 3. A tick in between leaves ss unchanged.
- In SET_HH at hh = 23, key_inc wraps to hh = 0 and mm is unchanged. Then key_next with key_inc in the same cycle at mm = 59: mm = 0, state SET_SS.
- BLINK_CYCLES = 4: after entering SET_MM, blank toggles every 4 clks. A key_inc clears blank the next cycle.
- TIMEOUT_TICKS = 3 in SET_SS with no keys: after the 3rd tick, setting = 0 and field_sel = 0. The next tick increments ss.
- With HMS_SET_CTRL_12H_EN: hh = 0, 12, 13 give hh12/pm = 12/0, 12/1, 1/1. rst_n low mid-set gives all outputs at reset values asynchronously.
